// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: dual-write register file with optional write bypass and pending-write scoreboard
module regfile_scoreboard #(
  parameter int WIDTH = 32,
  parameter int AW = 5,
  parameter int BYPASS = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    A1,
  input  logic [AW-1:0]    A2,
  output logic [WIDTH-1:0] RD1,
  output logic [WIDTH-1:0] RD2,
  input  logic [AW-1:0]    A3,
  input  logic [WIDTH-1:0] WD3,
  input  logic             we3,
  input  logic [AW-1:0]    A4,
  input  logic [WIDTH-1:0] WD4,
  input  logic             we4,
  input  logic [AW-1:0]    RA,
  input  logic             re,
  output logic             busy1,
  output logic             busy2
);
  localparam int DEPTH = 2**AW;
  localparam bit BYP = BYPASS != 0;
  logic [WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0] pend;
  logic             byp;
  logic             w3_1, w4_1, w3_2, w4_2;
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int x = 0; x < DEPTH; x++) regs[x] <= '0;
      pend <= '0;
    end else begin
      if (we3 && A3 != '0) regs[A3] <= WD3;
      // port 4 is written last so it wins an address collision
      if (we4 && A4 != '0) regs[A4] <= WD4;
      for (int x = 1; x < DEPTH; x++)
        pend[x] <= (re && RA == AW'(x)) ? 1'b1 :
                   ((we3 && A3 == AW'(x)) || (we4 && A4 == AW'(x))) ? 1'b0 : pend[x];
    end
  end
  always_comb begin
    byp   = BYP && !rst;
    w3_1  = we3 && A3 == A1;
    w4_1  = we4 && A4 == A1;
    w3_2  = we3 && A3 == A2;
    w4_2  = we4 && A4 == A2;
    RD1   = (A1 == '0) ? '0 : (byp && w4_1) ? WD4 : (byp && w3_1) ? WD3 : regs[A1];
    RD2   = (A2 == '0) ? '0 : (byp && w4_2) ? WD4 : (byp && w3_2) ? WD3 : regs[A2];
    busy1 = !rst && pend[A1] && A1 != '0 && !(BYP && (w3_1 || w4_1));
    busy2 = !rst && pend[A2] && A2 != '0 && !(BYP && (w3_2 || w4_2));
  end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: directed checks plus a per-cycle model compare of bypass and non-bypass instances
module tb_regfile_scoreboard;
  logic        clk = 0, rst = 1;
  logic [4:0]  A1 = 0, A2 = 0, A3 = 0, A4 = 0, RA = 0;
  logic [31:0] WD3 = 0, WD4 = 0;
  logic        we3 = 0, we4 = 0, re = 0;
  logic [31:0] rd1_b, rd2_b, rd1_n, rd2_n;
  logic        busy1_b, busy2_b, busy1_n, busy2_n;
  int          checks = 0, failures = 0;
  logic [31:0] m [32];
  bit          p [32];
  bit          live = 0;

  always #5 clk = ~clk;

  regfile_scoreboard #(.WIDTH(32), .AW(5), .BYPASS(1)) u_dut (
    .clk(clk), .rst(rst), .A1(A1), .A2(A2), .RD1(rd1_b), .RD2(rd2_b),
    .A3(A3), .WD3(WD3), .we3(we3), .A4(A4), .WD4(WD4), .we4(we4),
    .RA(RA), .re(re), .busy1(busy1_b), .busy2(busy2_b));

  regfile_scoreboard #(.WIDTH(32), .AW(5), .BYPASS(0)) u_nb (
    .clk(clk), .rst(rst), .A1(A1), .A2(A2), .RD1(rd1_n), .RD2(rd2_n),
    .A3(A3), .WD3(WD3), .we3(we3), .A4(A4), .WD4(WD4), .we4(we4),
    .RA(RA), .re(re), .busy1(busy1_n), .busy2(busy2_n));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // model state: architectural registers and pending set, updated from the sampled inputs
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin m[i] = 0; p[i] = 0; end
      live = 1;
    end else begin
      if (we3) begin m[A3] = WD3; p[A3] = 0; end
      if (we4) begin m[A4] = WD4; p[A4] = 0; end
      if (re) p[RA] = 1;
      m[0] = 0;
      p[0] = 0;
    end
  end

  function automatic logic [31:0] exp_rd(input bit byp, input logic [4:0] a);
    if (a == 0) return 0;
    if (byp && !rst && we4 && A4 == a) return WD4;
    if (byp && !rst && we3 && A3 == a) return WD3;
    return m[a];
  endfunction

  function automatic logic exp_busy(input bit byp, input logic [4:0] a);
    if (rst || a == 0 || !p[a]) return 0;
    return !(byp && ((we3 && A3 == a) || (we4 && A4 == a)));
  endfunction

  always @(negedge clk) if (live) begin
    chk("model_rd1_byp", rd1_b, exp_rd(1, A1));
    chk("model_rd2_byp", rd2_b, exp_rd(1, A2));
    chk("model_rd1_nb", rd1_n, exp_rd(0, A1));
    chk("model_rd2_nb", rd2_n, exp_rd(0, A2));
    chk("model_busy1_byp", 32'(busy1_b), 32'(exp_busy(1, A1)));
    chk("model_busy2_byp", 32'(busy2_b), 32'(exp_busy(1, A2)));
    chk("model_busy1_nb", 32'(busy1_n), 32'(exp_busy(0, A1)));
    chk("model_busy2_nb", 32'(busy2_n), 32'(exp_busy(0, A2)));
  end

  task automatic next();
    @(posedge clk);
    #1;
    we3 = 0; we4 = 0; re = 0; rst = 0;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  initial begin
    next();
    // reset then read
    we3 = 1; A3 = 5; WD3 = 32'hDEADBEEF; re = 1; RA = 5; A1 = 5;
    next(); rst = 1; A1 = 5;
    at_neg();
    chk("rst_cycle_rd1_old", rd1_b, 32'hDEADBEEF);
    chk("rst_cycle_busy1", 32'(busy1_b), 0);
    next(); A1 = 5;
    at_neg();
    chk("post_rst_rd1", rd1_b, 0);
    chk("post_rst_busy1", 32'(busy1_b), 0);
    // zero register
    next(); we3 = 1; A3 = 0; WD3 = 32'hFFFFFFFF; re = 1; RA = 0; A1 = 0; A2 = 0;
    next(); A1 = 0;
    at_neg();
    chk("zero_rd1", rd1_b, 0);
    chk("zero_busy1", 32'(busy1_b), 0);
    // dual write
    next(); we3 = 1; A3 = 7; WD3 = 32'h11; we4 = 1; A4 = 8; WD4 = 32'h22;
    next(); A1 = 7; A2 = 8;
    at_neg();
    chk("dual_r7", rd1_n, 32'h11);
    chk("dual_r8", rd2_n, 32'h22);
    // conflict, port 4 wins
    next(); we3 = 1; A3 = 9; WD3 = 32'h33; we4 = 1; A4 = 9; WD4 = 32'h44; A1 = 9;
    at_neg();
    chk("conflict_byp_same", rd1_b, 32'h44);
    chk("conflict_nb_same", rd1_n, 0);
    next(); A1 = 9;
    at_neg();
    chk("conflict_r9", rd1_n, 32'h44);
    // bypass
    next(); we3 = 1; A3 = 12; WD3 = 32'hCAFE; A1 = 12;
    at_neg();
    chk("bypass_rd1", rd1_b, 32'hCAFE);
    chk("nobypass_rd1_old", rd1_n, 0);
    next(); A1 = 12;
    at_neg();
    chk("nobypass_rd1_next", rd1_n, 32'hCAFE);
    // scoreboard: reserve r3 in cycle 0, retire in cycle 4
    next(); re = 1; RA = 3; A1 = 3;
    at_neg();
    chk("sb_c0_busy1", 32'(busy1_b), 0);
    for (int c = 1; c < 4; c++) begin
      next(); A1 = 3;
      at_neg();
      chk("sb_pending_byp", 32'(busy1_b), 1);
      chk("sb_pending_nb", 32'(busy1_n), 1);
    end
    next(); we4 = 1; A4 = 3; WD4 = 32'h55; A1 = 3;
    at_neg();
    chk("sb_c4_byp", 32'(busy1_b), 0);
    chk("sb_c4_nb", 32'(busy1_n), 1);
    next(); A1 = 3;
    at_neg();
    chk("sb_c5_nb", 32'(busy1_n), 0);
    // set beats clear
    next(); re = 1; RA = 6;
    next(); re = 1; RA = 6; we3 = 1; A3 = 6; WD3 = 32'h66; A2 = 6;
    at_neg();
    chk("sbc_same_byp", 32'(busy2_b), 0);
    chk("sbc_same_nb", 32'(busy2_n), 1);
    next(); A2 = 6;
    at_neg();
    chk("sbc_pend6", 32'(busy2_b), 1);
    chk("sbc_r6", rd2_b, 32'h66);
    // double reservation is cleared by a single write
    next(); re = 1; RA = 10;
    next(); re = 1; RA = 10;
    next(); we3 = 1; A3 = 10; WD3 = 32'h77;
    next(); A1 = 10;
    at_neg();
    chk("double_res_clear", 32'(busy1_n), 0);
    // reset mid-operation clears pending
    next(); re = 1; RA = 11;
    next(); rst = 1; A2 = 11;
    next(); A2 = 11;
    at_neg();
    chk("midrst_busy2", 32'(busy2_b), 0);
    chk("midrst_rd1_r10", 32'(rd1_b == 32'h0), 1);
    next();
    at_neg();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
